spi_arbiter: RTL and testbench
==============================

# spi_arbiter

Round-robin arbiter and sequencer that shares one `transmitter_SPI` master among `NREQ` requesters. Each requester posts a byte and an SPI mode. The arbiter grants one requester at a time and drives the transmitter's `strt`, `data_in`, `CPH` and `CKP`. It tracks the transfer through the transmitter's `CS` and returns a per-requester completion pulse. It sits between the client logic and the transmitter, in the same clock domain.

## Interface
Parameters:
- `NREQ`, 4: number of requesters (2..8).
- `TIMEOUT`, 1023: cycles allowed in each CS-wait state. Used only when `SPI_ARB_TIMEOUT_EN` is defined.

Ports:
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in NREQ: request per requester, level.
- `req_data` in NREQ*8: byte for requester i at bits [8i+7:8i].
- `req_mode` in NREQ*2: {CKP,CPH} for requester i at bits [2i+1:2i].
- `gnt` out NREQ: one-hot grant, registered.
- `done` out NREQ: one-cycle completion pulse to the served requester.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle timeout flag. Tied 0 without the macro.
- `strt` out 1: start pulse to the transmitter.
- `data_in` out 8: byte to the transmitter.
- `CPH`, `CKP` out 1: mode to the transmitter.
- `CS` in 1: chip select from the transmitter; low during a transfer.

## Operation
- FSM states: IDLE, START, WAIT_LOW, WAIT_HIGH, DONE. All outputs are registered.
- Reset (async, any state):
  - state=IDLE.
  - gnt=0, done=0, busy=0, err=0, strt=0, data_in=0, CPH=0, CKP=0.
  - Round-robin pointer ptr=NREQ-1, so requester 0 has highest priority after reset.
- IDLE, any req high:
  - Winner is the first set bit scanning ptr+1, ptr+2, … modulo NREQ.
  - Latch the winner's byte into data_in and its mode into CPH/CKP.
  - Set gnt[winner]=1 and go to START.
- IDLE, req=0: hold state. data_in, CPH and CKP keep their last values.
- START: strt=1 for exactly this cycle, then go to WAIT_LOW.
- WAIT_LOW: wait for CS sampled 0, then go to WAIT_HIGH.
- WAIT_HIGH: wait for CS sampled 1, then go to DONE.
- DONE:
  - done[winner]=1, gnt=0, ptr=winner.
  - Go to IDLE.
- data_in, CPH and CKP are stable from START through DONE.
- Requester protocol:
  - A requester holds req, req_data and req_mode until its done pulse.
  - Changes to those inputs after the grant are ignored.
  - Dropping req after the grant does not abort the transfer.
- A requester that drops req before being granted is not served.
- Re-asserting req in the same cycle as done is legal. That requester is then lowest priority in the next arbitration.

## Timing
- req sampled high in IDLE at cycle N:
  - gnt, data_in, CPH, CKP and strt=1 all appear at N+1.
  - strt=0 from N+2.
- CS first sampled 0 at cycle M moves the FSM to WAIT_HIGH at M+1.
- CS sampled 1 at cycle K in WAIT_HIGH: done pulses and gnt clears at K+1. IDLE at K+2.
- CS already high at entry to WAIT_HIGH is not completion, because completion requires a prior low.
- Back-to-back service:
  - The next arbitration happens in the IDLE cycle K+2.
  - The next strt fires at K+3.
  - Minimum gap between strt pulses is transfer length + 4 cycles.
- Simultaneous requests are served one per transaction in rotating order. A continuously requesting client waits at most NREQ-1 transactions.

## Configuration
- `SPI_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT_LOW and again on entry to WAIT_HIGH.
  - It increments each cycle in those states.
  - When it reaches TIMEOUT, the FSM goes to DONE with err=1 in the DONE cycle.
  - done[winner] still pulses and ptr still advances, so the requester is released.
- `SPI_ARB_TIMEOUT_EN` undefined:
  - No counter is built and err is constant 0.
  - The wait states wait indefinitely.

## Test plan
All scenarios use a bench CS model that drives CS low 2 cycles after strt and holds it low 16 cycles.
- Reset mid-WAIT_HIGH:
  - Every output goes to 0 asynchronously with no done pulse.
  - The next request starts from requester 0 priority.
- Single request, req[2]=1, req_data[23:16]=8'hA5, req_mode[5:4]=2'b10:
  - gnt=4'b0100, data_in=8'hA5, CKP=1, CPH=0 and strt pulse one cycle after request.
  - done[2] pulses one cycle after the CS rise.
- All four requesting continuously after reset:
  - Grant order is 0,1,2,3,0.
  - Exactly one strt per transaction, with no overlapping gnt bits.
- req[1] dropped two cycles after its grant: the transfer completes and done[1] still pulses.
- Timeout, macro defined, TIMEOUT=20, CS held high after strt: err=1 and done[0]=1 in the same cycle, 21 cycles after WAIT_LOW entry.
- Timeout, macro undefined, same stimulus: busy stays 1 and err stays 0 for 200 cycles.

Source files
------------

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: client request/grant bus plus transmitter control bundle for spi_arbiter
interface spi_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]   req;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ*2-1:0] req_mode;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic              busy;
  logic              err;
  logic              strt;
  logic [7:0]        data_in;
  logic              CPH;
  logic              CKP;
  logic              CS;
  modport slave (input req, req_data, req_mode, CS,
                 output gnt, done, busy, err, strt, data_in, CPH, CKP);
  modport master (output req, req_data, req_mode, CS,
                  input gnt, done, busy, err, strt, data_in, CPH, CKP);
endinterface

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sequencing NREQ clients onto one SPI transmitter
// Define SPI_ARB_TIMEOUT_EN to bound each CS-wait state by TIMEOUT cycles and flag err.
module spi_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input logic       clk,
  input logic       rst,
  spi_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, START, WAIT_LOW, WAIT_HIGH, DONE} state_t;
  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, done_q, done_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d;
  logic [7:0]      data_q, data_d;
  logic            cph_q, cph_d, ckp_q, ckp_d;
  logic            strt_q, strt_d, busy_q, busy_d, err_q, err_d;
  logic            found, fin;
  logic [PW:0]     sh, sum;
  logic [NREQ-1:0] rot;
  logic [PW-1:0]   pick;
  logic [7:0]      sel_data;
  logic [1:0]      sel_mode;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to;
`endif
  // Rotate requests so bit 0 is the requester just after the last winner.
  always_comb begin
    sh       = (PW+1)'(ptr_q) + (PW+1)'(1);
    rot      = NREQ'({bus.req, bus.req} >> sh);
    found    = |rot;
    sum      = sh;
    for (int k = NREQ - 1; k >= 0; k--)
      if (rot[k]) sum = sh + (PW+1)'(k);
    pick     = PW'((sum >= (PW+1)'(NREQ)) ? sum - (PW+1)'(NREQ) : sum);
    sel_data = '0;
    sel_mode = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick == PW'(i)) begin
        sel_data = bus.req_data[8*i +: 8];
        sel_mode = bus.req_mode[2*i +: 2];
      end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    ptr_d   = ptr_q;
    win_d   = win_q;
    data_d  = data_q;
    cph_d   = cph_q;
    ckp_d   = ckp_q;
    strt_d  = 1'b0;
    err_d   = 1'b0;
    fin     = (state_q == WAIT_HIGH) && bus.CS;
`ifdef SPI_ARB_TIMEOUT_EN
    to      = (((state_q == WAIT_LOW) && bus.CS) || ((state_q == WAIT_HIGH) && !bus.CS))
              && (cnt_q == CW'(TIMEOUT));
    fin     = fin || to;
    err_d   = to;
`endif
    case (state_q)
      IDLE: if (found) begin
        state_d        = START;
        win_d          = pick;
        gnt_d          = NREQ'(1) << pick;
        data_d         = sel_data;
        {ckp_d, cph_d} = sel_mode;
        strt_d         = 1'b1;
      end
      START:    state_d = WAIT_LOW;
      WAIT_LOW: state_d = bus.CS ? WAIT_LOW : WAIT_HIGH;
      DONE:     state_d = IDLE;
      default:  state_d = state_q;
    endcase
    if (fin) begin
      state_d = DONE;
      done_d  = gnt_q;
      gnt_d   = '0;
      ptr_d   = win_q;
    end
    busy_d = state_d != IDLE;
`ifdef SPI_ARB_TIMEOUT_EN
    cnt_d = ((state_q == WAIT_LOW || state_q == WAIT_HIGH) && state_d == state_q)
            ? cnt_q + CW'(1) : '0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      ptr_q   <= PW'(NREQ - 1);
      win_q   <= '0;
      data_q  <= '0;
      cph_q   <= 1'b0;
      ckp_q   <= 1'b0;
      strt_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      data_q  <= data_d;
      cph_q   <= cph_d;
      ckp_q   <= ckp_d;
      strt_q  <= strt_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef SPI_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign bus.gnt     = gnt_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.err     = err_q;
  assign bus.strt    = strt_q;
  assign bus.data_in = data_q;
  assign bus.CPH     = cph_q;
  assign bus.CKP     = ckp_q;
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: vector table plus done scoreboard for spi_arbiter with a simple CS model
module tb_spi_arbiter;
  localparam int N = 4;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TO = 20;
`else
  localparam int TO = 1023;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  spi_arbiter_if #(.NREQ(N)) bus();
  spi_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [N-1:0]   req;
    logic [8*N-1:0] data;
    logic [2*N-1:0] mode;
    logic [N-1:0]   exp_gnt;
    bit             drop;
  } vec_t;
  vec_t         vecs[9];
  logic [N-1:0] sb[$];
  int           checks = 0;
  int           errors = 0;
  bit           cs_en  = 1'b1;
  int           tmr    = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Transmitter stand-in: CS falls 2 cycles after strt and stays low 16 cycles.
  always @(negedge clk) begin
    if (rst) tmr = 0;
    else if (bus.strt) tmr = 1;
    else if (tmr != 0) tmr = (tmr == 18) ? 0 : tmr + 1;
    bus.CS = !(cs_en && tmr >= 3);
  end
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
      if (bus.done != '0) begin
        if (sb.size() == 0) chk("done_unexpected", bus.done, 0);
        else chk("done_sb", bus.done, sb.pop_front());
      end
    end
  end
  task automatic check_idle_zero(input string tag);
    chk({tag, "_gnt"}, bus.gnt, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_strt"}, bus.strt, 0);
    chk({tag, "_data"}, bus.data_in, 0);
    chk({tag, "_mode"}, {bus.CKP, bus.CPH}, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int  w, strts;
    bit  low, rose;
    @(negedge clk);
    bus.req      = v.req;
    bus.req_data = v.data;
    bus.req_mode = v.mode;
    @(posedge clk); #1;
    chk("gnt", bus.gnt, v.exp_gnt);
    chk("strt_on", bus.strt, 1);
    chk("busy", bus.busy, 1);
    w = 0;
    for (int i = 0; i < N; i++) if (v.exp_gnt[i]) w = i;
    chk("data_in", bus.data_in, v.data[8*w +: 8]);
    chk("ckp_cph", {bus.CKP, bus.CPH}, v.mode[2*w +: 2]);
    sb.push_back(v.exp_gnt);
    @(posedge clk); #1;
    chk("strt_off", bus.strt, 0);
    if (v.drop) begin
      @(negedge clk);
      bus.req = '0;
    end
    low = 0; rose = 0; strts = 0;
    for (int i = 0; i < 100 && !rose; i++) begin
      @(posedge clk); #1;
      strts += int'(bus.strt);
      if (!low) low = !bus.CS;
      else if (bus.CS) rose = 1;
    end
    chk("cs_rose", rose, 1);
    chk("done_at_rise", bus.done, v.exp_gnt);
    chk("gnt_clr", bus.gnt, 0);
    chk("strt_once", strts, 0);
    @(posedge clk); #1;
    chk("done_pulse", bus.done, 0);
    chk("busy_idle", bus.busy, 0);
  endtask
  initial begin
    int bad;
    vecs[0] = '{4'hF, 32'h44332211, 8'b11_10_01_00, 4'b0001, 0};
    vecs[1] = '{4'hF, 32'h44332211, 8'b11_10_01_00, 4'b0010, 0};
    vecs[2] = '{4'hF, 32'h44332211, 8'b11_10_01_00, 4'b0100, 0};
    vecs[3] = '{4'hF, 32'h44332211, 8'b11_10_01_00, 4'b1000, 0};
    vecs[4] = '{4'hF, 32'hDDCCBBAA, 8'b00_01_10_11, 4'b0001, 0};
    vecs[5] = '{4'b0100, 32'h00A50000, 8'b00_10_00_00, 4'b0100, 0};
    vecs[6] = '{4'b0010, 32'h00007E00, 8'b00_00_01_00, 4'b0010, 1};
    vecs[7] = '{4'b1001, 32'h5A0000C3, 8'b10_00_00_01, 4'b1000, 0};
    vecs[8] = '{4'b0101, 32'h00960069, 8'b00_11_00_10, 4'b0001, 0};
    bus.req = '0; bus.req_data = '0; bus.req_mode = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    bus.req = 4'hF; bus.req_data = 32'h44332211; bus.req_mode = 8'b11_10_01_11;
    @(posedge clk); #1;
    chk("pre_rst_gnt", bus.gnt, 4'b0001);
    for (int i = 0; i < 50 && bus.CS; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_cs_low", bus.CS, 0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_idle_zero("async_rst");
    @(negedge clk) bus.req = '0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);
    cs_en = 1'b0;
    @(negedge clk);
    bus.req = 4'b0001; bus.req_data = 32'h000000F0; bus.req_mode = '0;
    @(posedge clk); #1;
    chk("to_gnt", bus.gnt, 4'b0001);
`ifdef SPI_ARB_TIMEOUT_EN
    sb.push_back(4'b0001);
    @(posedge clk); #1;
    for (int i = 1; i <= 21; i++) begin
      @(posedge clk); #1;
    end
    chk("to_err", bus.err, 1);
    chk("to_done", bus.done, 4'b0001);
`else
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (!bus.busy || bus.err) bad++;
    end
    chk("hang_busy_err", bad, 0);
    chk("hang_err", bus.err, 0);
`endif
    @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    cs_en = 1'b1;
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
